// File: rtl/video_fb_scanout.sv
// Framebuffer scan-out: video timing, BRAM address generation and delay-matched sync/active/pixel outputs.
// Define TEST_PATTERN_EN to add the i_tp_en colour-bar override.
module video_fb_scanout #(
  parameter int            H_ACTIVE = 640,
  parameter int            H_FP     = 16,
  parameter int            H_SYNC   = 96,
  parameter int            H_BP     = 48,
  parameter int            V_ACTIVE = 480,
  parameter int            V_FP     = 10,
  parameter int            V_SYNC   = 2,
  parameter int            V_BP     = 33,
  parameter bit            HS_POL   = 1'b0,
  parameter bit            VS_POL   = 1'b0,
  parameter int            FB_W     = 320,
  parameter int            FB_H     = 240,
  parameter int            AW       = 18,
  parameter int            DW       = 16,
  parameter int            RD_LAT   = 1,
  parameter logic [DW-1:0] BORDER   = '0
) (
  input  logic          i_p_clk,
  input  logic          i_rstn,
  input  logic          i_mode,
`ifdef TEST_PATTERN_EN
  input  logic          i_tp_en,
`endif
  output logic [AW-1:0] o_raddr,
  input  logic [DW-1:0] i_rdata,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active,
  output logic [DW-1:0] o_rgb,
  output logic [11:0]   o_x,
  output logic [11:0]   o_y,
  output logic          o_frame_start
);

  localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned L       = RD_LAT + 2;

  localparam logic [11:0] HT_M1 = 12'(H_TOTAL - 1);
  localparam logic [11:0] VT_M1 = 12'(V_TOTAL - 1);
  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_B  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_E  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_B  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_E  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] FBW1  = 12'(FB_W);
  localparam logic [11:0] FBW2  = 12'(2 * FB_W);
  localparam logic [11:0] FBH1  = 12'(FB_H);
  localparam logic [11:0] FBH2  = 12'(2 * FB_H);
  localparam logic [AW-1:0] FBW_A = AW'(FB_W);

  if ((longint'(FB_W) * longint'(FB_H)) > (longint'(1) << AW)) begin : g_aw_chk
    $error("video_fb_scanout: FB_W*FB_H does not fit in AW address bits");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
    $error("video_fb_scanout: RD_LAT must be in 1..4");
  end

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fb;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: ~HS_POL, vs: ~VS_POL, act: 1'b0, fb: 1'b0,
                               fs: 1'b0, x: '0, y: '0};

  logic [11:0]   cx, cy;
  logic          mode_q;
  logic [AW-1:0] line_base;
  logic          end_line, end_frame;
  logic          act, hs_on, vs_on, fb;
  logic [11:0]   xoff;
  ctl_t          ctl_in;
  ctl_t          pipe_q [L];

  assign end_line  = (cx == HT_M1);
  assign end_frame = end_line && (cy == VT_M1);

  // Mode is only latched at the last position of a frame, together with the line-base restart,
  // so a frame is always scanned with a single scale factor.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      cx        <= '0;
      cy        <= '0;
      line_base <= '0;
      mode_q    <= 1'b0;
    end else if (end_line) begin
      cx <= '0;
      if (end_frame) begin
        cy        <= '0;
        line_base <= '0;
        mode_q    <= i_mode;
      end else begin
        cy <= cy + 12'd1;
        if (!mode_q || cy[0])
          line_base <= line_base + FBW_A;
      end
    end else begin
      cx <= cx + 12'd1;
    end
  end

  always_comb begin
    act    = (cx < HA) && (cy < VA);
    hs_on  = (cx >= HS_B) && (cx < HS_E);
    vs_on  = (cy >= VS_B) && (cy < VS_E);
    fb     = act && (mode_q ? ((cx < FBW2) && (cy < FBH2))
                            : ((cx < FBW1) && (cy < FBH1)));
    xoff   = mode_q ? {1'b0, cx[11:1]} : cx;
    ctl_in = '{hs: hs_on ? HS_POL : ~HS_POL, vs: vs_on ? VS_POL : ~VS_POL,
               act: act, fb: fb, fs: (cx == '0) && (cy == '0), x: cx, y: cy};
  end

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn)
      o_raddr <= '0;
    else if (fb)
      o_raddr <= line_base + AW'(xoff);
  end

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < L; i++)
        pipe_q[i] <= CTL_RST;
    end else begin
      pipe_q[0] <= ctl_in;
      for (int unsigned i = 1; i < L; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef TEST_PATTERN_EN
  logic          tp_q;
  logic [L-1:0]  tp_pipe;
  logic [2:0]    bar_idx;
  logic [DW-1:0] bar_rgb;

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      tp_q    <= 1'b0;
      tp_pipe <= '0;
    end else begin
      if (end_frame)
        tp_q <= i_tp_en;
      tp_pipe <= {tp_pipe[L-2:0], tp_q};
    end
  end

  // Bar index x*8/H_ACTIVE as threshold compares against constants.
  always_comb begin
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++)
      if ({pipe_q[L-2].x, 3'b000} >= 15'(k * H_ACTIVE))
        bar_idx = 3'(k);
    case (bar_idx)
      3'd0:    bar_rgb = DW'(16'hFFFF);
      3'd1:    bar_rgb = DW'(16'hFFE0);
      3'd2:    bar_rgb = DW'(16'h07FF);
      3'd3:    bar_rgb = DW'(16'h07E0);
      3'd4:    bar_rgb = DW'(16'hF81F);
      3'd5:    bar_rgb = DW'(16'hF800);
      3'd6:    bar_rgb = DW'(16'h001F);
      default: bar_rgb = DW'(16'h0000);
    endcase
  end
`endif

  // Stage L-2 lines up with the cycle in which the BRAM returns data for that position.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn)
      o_rgb <= '0;
    else if (!pipe_q[L-2].act)
      o_rgb <= '0;
    else if (!pipe_q[L-2].fb)
      o_rgb <= BORDER;
`ifdef TEST_PATTERN_EN
    else if (tp_pipe[L-2])
      o_rgb <= bar_rgb;
`endif
    else
      o_rgb <= i_rdata;
  end

  assign o_hsync       = pipe_q[L-1].hs;
  assign o_vsync       = pipe_q[L-1].vs;
  assign o_active      = pipe_q[L-1].act;
  assign o_frame_start = pipe_q[L-1].fs;
  assign o_x           = pipe_q[L-1].x;
  assign o_y           = pipe_q[L-1].y;

endmodule

// File: tb/tb_video_fb_scanout.sv
// Directed bench for video_fb_scanout on a reduced 24x17 raster with a 6x4 framebuffer;
// two instances cover RD_LAT=1 (latency 3) and RD_LAT=3 (latency 5).
module tb_video_fb_scanout;
  localparam int HT = 24;
  localparam int FR = 408;
  localparam logic [15:0] BRD = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  raddr1, raddr3;
  logic [15:0] rdata1, rdata3, rgb1, rgb3;
  logic [15:0] bram3 [2];
  logic        hs1, vs1, act1, fs1, hs3, vs3, act3, fs3;
  logic [11:0] x1, y1, x3, y3;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  // BRAM models: data equals address, RD_LAT cycles after o_raddr
  always @(posedge clk) begin
    rdata1   <= 16'(raddr1);
    bram3[0] <= 16'(raddr3);
    bram3[1] <= bram3[0];
    rdata3   <= bram3[1];
  end

  video_fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .FB_W(6), .FB_H(4), .AW(8), .DW(16), .RD_LAT(1), .BORDER(BRD)
  ) u_dut1 (
    .i_p_clk(clk), .i_rstn(rstn), .i_mode(mode),
`ifdef TEST_PATTERN_EN
    .i_tp_en(1'b0),
`endif
    .o_raddr(raddr1), .i_rdata(rdata1), .o_hsync(hs1), .o_vsync(vs1),
    .o_active(act1), .o_rgb(rgb1), .o_x(x1), .o_y(y1), .o_frame_start(fs1)
  );

  video_fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .FB_W(6), .FB_H(4), .AW(8), .DW(16), .RD_LAT(3), .BORDER(BRD)
  ) u_dut3 (
    .i_p_clk(clk), .i_rstn(rstn), .i_mode(mode),
`ifdef TEST_PATTERN_EN
    .i_tp_en(1'b0),
`endif
    .o_raddr(raddr3), .i_rdata(rdata3), .o_hsync(hs3), .o_vsync(vs3),
    .o_active(act3), .o_rgb(rgb3), .o_x(x3), .o_y(y3), .o_frame_start(fs3)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cyc counts edges since the last reset edge; instance latency L shows position p at cyc p+L
  task automatic go(input int k);
    if (k < cyc) begin
      checks++;
      errors++;
      $display("FAIL seq target=%0d current=%0d", k, cyc);
    end
    while (cyc < k) step();
  endtask

  function automatic int pos(input int fr, input int x, input int y);
    return fr * FR + y * HT + x;
  endfunction

  initial begin
    repeat (10) step();
    chk("rst_hs1", 32'(hs1), 32'd1);
    chk("rst_vs1", 32'(vs1), 32'd1);
    chk("rst_act1", 32'(act1), 32'd0);
    chk("rst_raddr1", 32'(raddr1), 32'd0);
    chk("rst_rgb1", 32'(rgb1), 32'd0);
    chk("rst_fs1", 32'(fs1), 32'd0);
    chk("rst_x1", 32'(x1), 32'd0);
    chk("rst_act3", 32'(act3), 32'd0);
    chk("rst_hs3", 32'(hs3), 32'd1);
    rstn = 1'b1;
    cyc = 0;

    // native frame 0
    go(2);  chk("pre_act1", 32'(act1), 32'd0);
            chk("pre_fs1", 32'(fs1), 32'd0);
    go(3);  chk("fs1_00", 32'(fs1), 32'd1);
            chk("act1_00", 32'(act1), 32'd1);
            chk("y1_00", 32'(y1), 32'd0);
            chk("rgb1_00", 32'(rgb1), 32'd0);
    go(4);  chk("act3_early", 32'(act3), 32'd0);
    go(5);  chk("act3_rise", 32'(act3), 32'd1);
            chk("fs3_00", 32'(fs3), 32'd1);
    go(pos(0,5,2)+1); chk("raddr1_5_2", 32'(raddr1), 32'd17);
                      chk("raddr3_5_2", 32'(raddr3), 32'd17);
    go(pos(0,5,2)+3); chk("rgb1_5_2", 32'(rgb1), 32'd17);
                      chk("x1_5_2", 32'(x1), 32'd5);
                      chk("y1_5_2", 32'(y1), 32'd2);
    go(pos(0,8,2)+1); chk("raddr1_hold", 32'(raddr1), 32'd17);
    go(pos(0,5,2)+5); chk("rgb3_5_2", 32'(rgb3), 32'd17);
    go(pos(0,8,2)+3); chk("rgb1_border_x", 32'(rgb1), 32'(BRD));
                      chk("act1_border_x", 32'(act1), 32'd1);
    go(pos(0,5,3)+3); chk("rgb1_5_3", 32'(rgb1), 32'd23);
    go(pos(0,3,5)+3); chk("rgb1_border_y", 32'(rgb1), 32'(BRD));
    go(pos(0,17,6)+3); chk("hs1_before", 32'(hs1), 32'd1);
                       chk("act1_blank", 32'(act1), 32'd0);
                       chk("rgb1_blank", 32'(rgb1), 32'd0);
    go(pos(0,18,6)+3); chk("hs1_first", 32'(hs1), 32'd0);
    go(pos(0,20,6)+3); chk("hs1_last", 32'(hs1), 32'd0);
    go(pos(0,21,6)+3); chk("hs1_after", 32'(hs1), 32'd1);
    go(pos(0,0,12)+3); chk("vs1_before", 32'(vs1), 32'd1);
    go(pos(0,0,13)+3); chk("vs1_first", 32'(vs1), 32'd0);
    go(pos(0,23,14)+3); chk("vs1_last", 32'(vs1), 32'd0);
    go(pos(0,0,15)+3); chk("vs1_after", 32'(vs1), 32'd1);
    go(pos(0,23,16)+3); chk("fs1_end", 32'(fs1), 32'd0);
    go(pos(1,0,0)+3); chk("fs1_period", 32'(fs1), 32'd1);
                      chk("x1_f1", 32'(x1), 32'd0);

    // mid-frame mode request: frame 1 stays native
    go(pos(1,0,2)); mode = 1'b1;
    go(pos(1,5,3)+3); chk("f1_native_5_3", 32'(rgb1), 32'd23);
    go(pos(1,9,3)+3); chk("f1_native_9_3", 32'(rgb1), 32'(BRD));

    // frame 2 upscaled
    go(pos(2,8,2)+3); chk("up_8_2", 32'(rgb1), 32'd10);
    go(pos(2,9,2)+3); chk("up_9_2", 32'(rgb1), 32'd10);
    go(pos(2,8,3)+3); chk("up_8_3", 32'(rgb1), 32'd10);
    go(pos(2,9,3)+3); chk("up_9_3", 32'(rgb1), 32'd10);
    go(pos(2,9,3)+5); chk("up3_9_3", 32'(rgb3), 32'd10);
    go(pos(2,0,7)+3); chk("up_base_0_7", 32'(rgb1), 32'd18);
    go(pos(2,11,7)+1); chk("up_raddr_11_7", 32'(raddr1), 32'd23);
    go(pos(2,11,7)+3); chk("up_11_7", 32'(rgb1), 32'd23);
    go(pos(2,12,7)+3); chk("up_border_x", 32'(rgb1), 32'(BRD));
    go(pos(2,3,8)+3); chk("up_border_y", 32'(rgb1), 32'(BRD));

    // mid-frame reset
    rstn = 1'b0;
    step();
    chk("mrst_act1", 32'(act1), 32'd0);
    chk("mrst_hs1", 32'(hs1), 32'd1);
    chk("mrst_vs1", 32'(vs1), 32'd1);
    chk("mrst_raddr1", 32'(raddr1), 32'd0);
    chk("mrst_rgb1", 32'(rgb1), 32'd0);
    chk("mrst_fs1", 32'(fs1), 32'd0);
    chk("mrst_y1", 32'(y1), 32'd0);
    chk("mrst_act3", 32'(act3), 32'd0);
    chk("mrst_rgb3", 32'(rgb3), 32'd0);
    step();
    rstn = 1'b1;
    cyc = 0;
    go(3); chk("rs_fs1", 32'(fs1), 32'd1);
           chk("rs_x1", 32'(x1), 32'd0);
    go(5); chk("rs_fs3", 32'(fs3), 32'd1);
    go(pos(0,5,2)+3); chk("rs_native_5_2", 32'(rgb1), 32'd17);
    go(pos(0,9,3)+3); chk("rs_native_9_3", 32'(rgb1), 32'(BRD));
    go(pos(1,0,0)+3); chk("rs_fs1_f1", 32'(fs1), 32'd1);
    go(pos(1,9,3)+3); chk("rs_up_9_3", 32'(rgb1), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
